// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable one-shot/periodic down counter with terminal-count pulse.
// Define SYNC_DOWN_COUNTER_TC_COUNT_EN to add the 8-bit tc_count event counter output.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode_periodic,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
`ifdef SYNC_DOWN_COUNTER_TC_COUNT_EN
  output logic [7:0]       tc_count,
`endif
  output logic             tc_pulse
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
  logic             periodic_q, periodic_d, tc_q, tc_d;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;
    if (load) begin
      cnt_d      = load_val;
      reload_d   = load_val;
      periodic_d = mode_periodic;
      state_d    = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      // reaching one is the terminal step; reload comes in the same edge so periodic has no dead cycle
      tc_d    = (cnt_q == WIDTH'(1));
      cnt_d   = !tc_d ? cnt_q - WIDTH'(1) : periodic_q ? reload_q : '0;
      state_d = (tc_d && !periodic_q) ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
    end
  end
`ifdef SYNC_DOWN_COUNTER_TC_COUNT_EN
  logic [7:0] tc_count_q;
  always_ff @(posedge clk) begin
    if (reset) tc_count_q <= '0;
    else tc_count_q <= tc_count_q + 8'(tc_d);
  end
  assign tc_count = tc_count_q;
`endif
  assign q        = cnt_q;
  assign zero     = (cnt_q == '0);
  assign busy     = (state_q == RUN);
  assign tc_pulse = tc_q;
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: scoreboard bench; a behavioural model queues expected outputs per driven cycle.
module tb_sync_down_counter;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, mode_periodic = 1'b0, en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic zero, busy, tc_pulse;
`ifdef SYNC_DOWN_COUNTER_TC_COUNT_EN
  logic [7:0] tc_count;
`endif
  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .mode_periodic(mode_periodic), .en(en), .q(q), .zero(zero), .busy(busy),
`ifdef SYNC_DOWN_COUNTER_TC_COUNT_EN
    .tc_count(tc_count),
`endif
    .tc_pulse(tc_pulse));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [W-1:0] q;
    logic zero, busy, tc;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  logic [W-1:0] m_q = '0, m_rel = '0;
  logic m_per = 1'b0, m_run = 1'b0, m_tc = 1'b0;
  logic [7:0] m_cnt = '0;
  task automatic drive(input logic r, input logic l, input logic [W-1:0] lv, input logic mp, input logic en_v);
    @(negedge clk);
    reset = r; load = l; load_val = lv; mode_periodic = mp; en = en_v;
    if (r) begin
      m_q = '0; m_rel = '0; m_per = 1'b0; m_run = 1'b0; m_tc = 1'b0; m_cnt = '0;
    end else if (l) begin
      m_q = lv; m_rel = lv; m_per = mp; m_run = (lv != 0); m_tc = 1'b0;
    end else if (m_run && en_v && m_q > 1) begin
      m_q = m_q - 1'b1; m_tc = 1'b0;
    end else if (m_run && en_v) begin
      m_tc = 1'b1; m_cnt = m_cnt + 8'd1;
      if (m_per) m_q = m_rel;
      else begin m_q = '0; m_run = 1'b0; end
    end else m_tc = 1'b0;
    sb.push_back('{q: m_q, zero: (m_q == 0), busy: m_run, tc: m_tc, cnt: m_cnt});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 7; i++) begin
      drive(i < 2, 1'b0, '0, 1'b0, i >= 2);
      e = sb.pop_front(); checks++;
      if ({q, zero, busy, tc_pulse} !== {e.q, e.zero, e.busy, e.tc}) begin
        failures++;
        $display("FAIL reset c%0d got q=%0d z=%b b=%b tc=%b want q=%0d z=%b b=%b tc=%b", i, q, zero, busy, tc_pulse, e.q, e.zero, e.busy, e.tc);
      end
    end
    checks++;
    if ({q, zero, busy, tc_pulse} !== {4'd0, 3'b100}) begin
      failures++; $display("FAIL idle_after_reset got q=%0d z=%b b=%b tc=%b want 0 1 0 0", q, zero, busy, tc_pulse);
    end
  endtask
  task automatic test_one_shot();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, i == 0, 4'd5, 1'b0, 1'b1);
      e = sb.pop_front(); checks++;
      if ({q, zero, busy, tc_pulse} !== {e.q, e.zero, e.busy, e.tc}) begin
        failures++;
        $display("FAIL one_shot c%0d got q=%0d z=%b b=%b tc=%b want q=%0d z=%b b=%b tc=%b", i, q, zero, busy, tc_pulse, e.q, e.zero, e.busy, e.tc);
      end
      if (i == 5) begin
        checks++;
        if ({q, busy, tc_pulse} !== {4'd0, 2'b01}) begin
          failures++; $display("FAIL one_shot_tc got q=%0d b=%b tc=%b want 0 0 1", q, busy, tc_pulse);
        end
      end
    end
  endtask
  task automatic test_periodic_gated();
    int tcs = 0;
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, i == 0, 4'd3, 1'b1, i[0]);
      e = sb.pop_front(); checks++;
      if ({q, zero, busy, tc_pulse} !== {e.q, e.zero, e.busy, e.tc}) begin
        failures++;
        $display("FAIL periodic c%0d got q=%0d z=%b b=%b tc=%b want q=%0d z=%b b=%b tc=%b", i, q, zero, busy, tc_pulse, e.q, e.zero, e.busy, e.tc);
      end
      if (tc_pulse === 1'b1) tcs++;
    end
    checks++;
    if (tcs != 2 || busy !== 1'b1 || q !== 4'd3) begin
      failures++; $display("FAIL periodic_totals got tcs=%0d b=%b q=%0d want 2 1 3", tcs, busy, q);
    end
  endtask
  task automatic test_reload_zero();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, i == 0 || i >= 9, i == 0 ? 4'd9 : i == 9 ? 4'd4 : 4'd0, 1'b0, 1'b1);
      e = sb.pop_front(); checks++;
      if ({q, zero, busy, tc_pulse} !== {e.q, e.zero, e.busy, e.tc}) begin
        failures++;
        $display("FAIL reload c%0d got q=%0d z=%b b=%b tc=%b want q=%0d z=%b b=%b tc=%b", i, q, zero, busy, tc_pulse, e.q, e.zero, e.busy, e.tc);
      end
      if (i == 9) begin
        checks++;
        if ({q, busy, tc_pulse} !== {4'd4, 2'b10}) begin
          failures++; $display("FAIL reload_mid got q=%0d b=%b tc=%b want 4 1 0", q, busy, tc_pulse);
        end
      end
    end
    checks++;
    if ({q, zero, busy, tc_pulse} !== {4'd0, 3'b100}) begin
      failures++; $display("FAIL zero_load got q=%0d z=%b b=%b tc=%b want 0 1 0 0", q, zero, busy, tc_pulse);
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      drive(i == 9, i == 0 || i == 9, 4'd15, 1'b1, 1'b1);
      e = sb.pop_front(); checks++;
      if ({q, zero, busy, tc_pulse} !== {e.q, e.zero, e.busy, e.tc}) begin
        failures++;
        $display("FAIL reset_mid c%0d got q=%0d z=%b b=%b tc=%b want q=%0d z=%b b=%b tc=%b", i, q, zero, busy, tc_pulse, e.q, e.zero, e.busy, e.tc);
      end
      if (i == 8) begin
        checks++;
        if (q !== 4'd7) begin failures++; $display("FAIL reset_mid_pre got q=%0d want 7", q); end
      end
    end
    checks++;
    if ({q, busy, tc_pulse} !== {4'd0, 2'b00}) begin
      failures++; $display("FAIL reset_mid_post got q=%0d b=%b tc=%b want 0 0 0", q, busy, tc_pulse);
    end
  endtask
  task automatic test_max_period();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, i == 0, 4'd15, 1'b0, 1'b1);
      e = sb.pop_front(); checks++;
      if ({q, zero, busy, tc_pulse} !== {e.q, e.zero, e.busy, e.tc}) begin
        failures++;
        $display("FAIL max_period c%0d got q=%0d z=%b b=%b tc=%b want q=%0d z=%b b=%b tc=%b", i, q, zero, busy, tc_pulse, e.q, e.zero, e.busy, e.tc);
      end
    end
  endtask
`ifdef SYNC_DOWN_COUNTER_TC_COUNT_EN
  task automatic test_tc_count();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 261; i++) begin
      drive(1'b0, i == 0, 4'd1, 1'b1, 1'b1);
      e = sb.pop_front(); checks++;
      if ({q, busy, tc_pulse, tc_count} !== {e.q, e.busy, e.tc, e.cnt} || (i > 0 && tc_pulse !== 1'b1)) begin
        failures++;
        $display("FAIL tc_count c%0d got q=%0d b=%b tc=%b cnt=%0d want q=%0d b=%b tc=%b cnt=%0d", i, q, busy, tc_pulse, tc_count, e.q, e.busy, e.tc, e.cnt);
      end
    end
    checks++;
    if (tc_count !== 8'd4) begin failures++; $display("FAIL tc_count_wrap got %0d want 4", tc_count); end
  endtask
`endif
  initial begin
    test_reset();
    test_one_shot();
    test_periodic_gated();
    test_reload_zero();
    test_reset_mid();
    test_max_period();
`ifdef SYNC_DOWN_COUNTER_TC_COUNT_EN
    test_tc_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
